// File: rtl/or_reduce_pipe.sv
// or_reduce_pipe: three-stage OR-reduction tree with valid/ready flow
// control, a sticky hit flag and a saturating hit counter.
module or_reduce_pipe #(
  parameter int W     = 128,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VLD,
  input  logic [W-1:0]     IN_DATA,
  output logic             IN_RDY,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic             OUT_ANY,
  output logic [W/4-1:0]   OUT_GRP,
  input  logic             CLR,
  output logic             STICKY,
  output logic [CNT_W-1:0] HIT_CNT
);

  localparam int G1W = W / 4;
  localparam int G2W = W / 16;
  localparam int G3W = W / 64;

  logic             s1_vld_q;
  logic [G1W-1:0]   s1_g1_q;
  logic             s2_vld_q;
  logic [G1W-1:0]   s2_g1_q;
  logic [G2W-1:0]   s2_g2_q;
  logic             s3_vld_q;
  logic [G1W-1:0]   s3_g1_q;
  logic             s3_any_q;
  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [G1W-1:0]   g1_d;
  logic [G2W-1:0]   g2_d;
  logic [G3W-1:0]   g3_d;
  logic             any_d;
  logic             en1;
  logic             en2;
  logic             en3;
  logic             hit;

  // Reduction tree: nibble ORs, then ORs of four flags per level.
  always_comb begin
    g1_d = '0;
    g2_d = '0;
    g3_d = '0;
    for (int i = 0; i < G1W; i++)
      g1_d[i] = |IN_DATA[4*i +: 4];
    for (int j = 0; j < G2W; j++)
      g2_d[j] = |s1_g1_q[4*j +: 4];
    for (int k = 0; k < G3W; k++)
      g3_d[k] = |s2_g2_q[4*k +: 4];
    any_d = |g3_d;
  end

  // A stage may load when it is empty or its content moves on.
  assign en3    = !s3_vld_q || OUT_RDY;
  assign en2    = !s2_vld_q || en3;
  assign en1    = !s1_vld_q || en2;
  assign IN_RDY = en1 && !RST;

  // Stage 1: register nibble flags of the accepted beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld_q <= 1'b0;
      s1_g1_q  <= '0;
    end else if (en1) begin
      s1_vld_q <= IN_VLD;
      if (IN_VLD) s1_g1_q <= g1_d;
    end
  end

  // Stage 2: register 16-bit group flags, carry nibble flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_vld_q <= 1'b0;
      s2_g1_q  <= '0;
      s2_g2_q  <= '0;
    end else if (en2) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_g1_q <= s1_g1_q;
        s2_g2_q <= g2_d;
      end
    end
  end

  // Stage 3: register the final ANY with nibble flags; holds on stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s3_vld_q <= 1'b0;
      s3_g1_q  <= '0;
      s3_any_q <= 1'b0;
    end else if (en3) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_g1_q  <= s2_g1_q;
        s3_any_q <= any_d;
      end
    end
  end

  assign hit = s3_vld_q && OUT_RDY && s3_any_q;

  // Sticky/counter next state: a delivered hit wins over a clear.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (hit) begin
      sticky_d = 1'b1;
      if (CLR)
        cnt_d = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (CLR) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  // Sticky flag and saturating hit counter state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign OUT_VLD = s3_vld_q;
  assign OUT_ANY = s3_any_q;
  assign OUT_GRP = s3_g1_q;
  assign STICKY  = sticky_q;
  assign HIT_CNT = cnt_q;

endmodule

// File: tb/tb_or_reduce_pipe.sv
// tb_or_reduce_pipe: scoreboard bench, directed scenarios plus
// randomized traffic with random backpressure and clears.
module tb_or_reduce_pipe;

  localparam int W     = 128;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VLD = 1'b0;
  logic [W-1:0]     IN_DATA = '0;
  logic             IN_RDY;
  logic             OUT_VLD;
  logic             OUT_RDY = 1'b1;
  logic             OUT_ANY;
  logic [W/4-1:0]   OUT_GRP;
  logic             CLR = 1'b0;
  logic             STICKY;
  logic [CNT_W-1:0] HIT_CNT;

  or_reduce_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_DATA(IN_DATA),
    .IN_RDY(IN_RDY), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
    .OUT_ANY(OUT_ANY), .OUT_GRP(OUT_GRP), .CLR(CLR),
    .STICKY(STICKY), .HIT_CNT(HIT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          any;
    logic [W/4-1:0] grp;
    int            stamp;
  } exp_t;

  exp_t q[$];
  int   dq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   m_sticky = 0;
  int   m_cnt = 0;
  bit   rst_prev = 0;
  bit   rnd_done = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t r;
    r.any = (d != 0);
    r.grp = '0;
    for (int i = 0; i < W/4; i++)
      r.grp[i] = (((d >> (4*i)) & 128'hF) != 0);
    r.stamp = cyc;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    int mode;
    mode = $urandom_range(0, 3);
    d = {$urandom, $urandom, $urandom, $urandom};
    if (mode == 0) d = '0;
    else if (mode == 1) d = 128'h1 << $urandom_range(0, W-1);
    return d;
  endfunction

  function automatic logic [W-1:0] hit_data();
    logic [W-1:0] d;
    d = 128'h1 << $urandom_range(0, W-1);
    return d;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: counter model, reset checks, scoreboard pops.
  initial forever begin
    exp_t e;
    bit   hit;
    @(negedge CLK);
    if (rst_prev) begin
      chk("rst_out_vld", OUT_VLD, 0);
      chk("rst_out_any", OUT_ANY, 0);
      chk("rst_out_grp", OUT_GRP, 0);
      chk("rst_sticky", STICKY, 0);
      chk("rst_hit_cnt", HIT_CNT, 0);
      if (!RST) chk("rst_in_rdy", IN_RDY, 1);
    end else begin
      chk("sticky", STICKY, m_sticky);
      chk("hit_cnt", HIT_CNT, m_cnt);
    end
    if (RST) begin
      q.delete();
      m_sticky = 0;
      m_cnt = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      hit = 0;
      if (OUT_VLD && OUT_RDY) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_any", OUT_ANY, e.any);
          chk("out_grp", OUT_GRP, e.grp);
          chk("latency_ge3", (cyc - e.stamp) >= 3, 1);
          dq.push_back(cyc);
          hit = e.any;
        end
      end
      if (hit) begin
        m_sticky = 1;
        if (CLR) m_cnt = 1;
        else if (m_cnt < CMAX) m_cnt++;
      end else if (CLR) begin
        m_sticky = 0;
        m_cnt = 0;
      end
    end
  end

  task automatic send(input logic [W-1:0] d);
    bit acc = 0;
    IN_VLD = 1'b1;
    IN_DATA = d;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge CLK);
      if (IN_RDY) begin
        q.push_back(model(d));
        acc = 1;
      end
      @(posedge CLK);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    IN_VLD = 1'b0;
  endtask

  task automatic drain();
    int t;
    OUT_RDY = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge CLK);
      #1;
      t++;
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;

    // Single zero beat: exact latency and no hit.
    send('0);
    @(negedge CLK);
    chk("t1_vld_c1", OUT_VLD, 0);
    @(negedge CLK);
    chk("t1_vld_c2", OUT_VLD, 0);
    @(negedge CLK);
    chk("t1_vld_c3", OUT_VLD, 1);
    @(posedge CLK);
    #1;
    drain();
    chk("t1_hit_cnt", HIT_CNT, 0);

    // Single top-bit beat.
    do_reset();
    send(128'h1 << 127);
    drain();
    chk("t2_sticky", STICKY, 1);
    chk("t2_hit_cnt", HIT_CNT, 1);

    // Ten back-to-back beats, odd ones nonzero.
    do_reset();
    dq.delete();
    for (int i = 0; i < 10; i++)
      send((i % 2) ? hit_data() | rnd_data() : '0);
    drain();
    chk("t3_count", dq.size(), 10);
    if (dq.size() == 10) chk("t3_rate", dq[9] - dq[0], 9);
    chk("t3_hit_cnt", HIT_CNT, 5);

    // Backpressure: three beats fill the pipe.
    do_reset();
    OUT_RDY = 1'b0;
    IN_VLD = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      IN_DATA = rnd_data();
      @(negedge CLK);
      if (IN_RDY) begin
        q.push_back(model(IN_DATA));
        acc++;
      end
      @(posedge CLK);
      #1;
    end
    chk("t4_accepted", acc, 3);
    chk("t4_in_rdy_low", IN_RDY, 0);
    IN_VLD = 1'b0;
    drain();

    // Clear coinciding with a hit, then saturation.
    do_reset();
    for (int i = 0; i < 7; i++) send(hit_data());
    drain();
    chk("t5_hit_cnt7", HIT_CNT, 7);
    send(hit_data());
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk("t5_out_vld", OUT_VLD, 1);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("t5_clr_hit_cnt", HIT_CNT, 1);
    chk("t5_clr_sticky", STICKY, 1);
    for (int i = 0; i < 20; i++) send(hit_data());
    drain();
    chk("t5_sat", HIT_CNT, CMAX);

    // Reset with two beats in flight.
    send(hit_data());
    send(hit_data());
    do_reset();
    @(negedge CLK);
    chk("t6_in_rdy", IN_RDY, 1);
    chk("t6_hit_cnt", HIT_CNT, 0);
    chk("t6_sticky", STICKY, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("t6_no_vld", OUT_VLD, 0);
    end
    @(posedge CLK);
    #1;

    // Randomized traffic with random backpressure and clears.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rnd_data());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge CLK);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          OUT_RDY = ($urandom_range(0, 2) != 0);
          CLR = ($urandom_range(0, 15) == 0);
          @(posedge CLK);
          #1;
        end
        CLR = 1'b0;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or_reduce_pipe.md
OR_REDUCE_PIPE -- requirements
Module: or_reduce_pipe

Interface
Parameters:
REQ-001 SHALL provide parameter W, default 128, input data width; legal values are positive multiples of 64.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the hit counter.
Ports:
REQ-003 SHALL provide CLK  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL provide RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide IN_VLD  input  1  upstream beat valid.
REQ-006 SHALL provide IN_DATA  input  W  word to OR-reduce.
REQ-007 SHALL provide IN_RDY  output  1  block accepts a beat this cycle.
REQ-008 SHALL provide OUT_VLD  output  1  result valid.
REQ-009 SHALL provide OUT_RDY  input  1  downstream accepts the result.
REQ-010 SHALL provide OUT_ANY  output  1  OR of all W bits of the beat.
REQ-011 SHALL provide OUT_GRP  output  W/4  4-bit group flags of the beat; bit i = OR of IN_DATA[4i+3:4i].
REQ-012 SHALL provide CLR  input  1  clear sticky flag and counter.
REQ-013 SHALL provide STICKY  output  1  an ANY=1 result has been delivered since the last CLR/RST.
REQ-014 SHALL provide HIT_CNT  output  CNT_W  count of delivered results with ANY=1.

Function
REQ-015 SHALL reduce in a 3-stage register pipeline S1, S2, S3, each stage holding its own valid bit.
- S1: W/4 four-input ORs (IN_DATA -> G1), registered.
- S2: W/16 four-input ORs of G1 -> G2, registered; G1 carried alongside.
- S3: four-input ORs of G2 -> G3 (W/64 bits), then OR of G3 -> ANY, registered with G1.
REQ-016 SHALL transfer an input beat when IN_VLD and IN_RDY are both 1, and deliver it when OUT_VLD and OUT_RDY are both 1.
REQ-017 SHALL give a latency of 3 cycles from input transfer to OUT_VLD=1 with no backpressure, and sustain 1 beat per cycle while OUT_RDY=1.
REQ-018 SHALL advance stage k when stage k+1 is empty or advancing in the same cycle; S3 advances when empty or when OUT_RDY=1.
REQ-019 SHALL drive IN_RDY = !S1.valid | S1 advances; IN_RDY is combinational from OUT_RDY and the stage valids, and forced to 0 while RST=1.
REQ-020 SHALL hold OUT_ANY and OUT_GRP stable while OUT_VLD=1 and OUT_RDY=0, and lose or duplicate no beat under any backpressure pattern.
REQ-021 SHALL let a stalled stage ignore IN_DATA changes; there is no combinational path from IN_DATA to any output.
REQ-022 SHALL set STICKY, and increment HIT_CNT, on each delivery with OUT_ANY=1.
REQ-023 SHALL saturate HIT_CNT at 2^CNT_W-1; further hits leave it unchanged.
REQ-024 SHALL resolve CLR in the same cycle as a hit delivery as follows: STICKY=1 and HIT_CNT=1 the next cycle (the new hit wins over the clear).
REQ-025 SHALL act on CLR alone as follows: STICKY=0 and HIT_CNT=0 the next cycle; the pipeline contents are unaffected.

Reset
REQ-026 SHALL, on RST=1 at a clock edge, clear all stage valids, OUT_VLD, OUT_ANY, OUT_GRP, STICKY and HIT_CNT to 0.
REQ-027 SHALL give RST priority over all other inputs, including CLR and handshakes.
REQ-028 SHALL discard in-flight beats when RST is asserted mid-operation; none is delivered after reset.
REQ-029 SHALL drive IN_RDY=1 in the first cycle after RST deasserts.

Verification
REQ-030 SHALL cover: single beat IN_DATA=128'h0 with OUT_RDY=1 -> OUT_VLD at cycle 3, OUT_ANY=0, OUT_GRP=32'h0, HIT_CNT=0.
REQ-031 SHALL cover: single beat IN_DATA=128'h1<<127 -> OUT_ANY=1, OUT_GRP=32'h8000_0000, STICKY=1, HIT_CNT=1.
REQ-032 SHALL cover: 10 back-to-back beats, odd beats nonzero, OUT_RDY=1 -> 10 results in order at 1 beat/cycle, HIT_CNT=5.
REQ-033 SHALL cover: OUT_RDY=0 for 6 cycles with IN_VLD=1 -> IN_RDY falls after 3 accepted beats; on release those 3 beats are delivered in order with no loss.
REQ-034 SHALL cover: CLR in the same cycle as an ANY=1 delivery, HIT_CNT=7 beforehand -> HIT_CNT=1, STICKY=1; CNT_W=4 with 20 hits -> HIT_CNT=15.
REQ-035 SHALL cover: RST with 2 beats in flight -> no OUT_VLD afterwards, all outputs 0, IN_RDY=1 the cycle after RST drops.
